uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Serial transmitter for the UART link: the opposite end of the oversampling receiver. It accepts a parallel word through a valid/busy handshake. It then drives a framed asynchronous serial line (start bit, LSB-first data, optional parity bit, stop bit), holding each bit for exactly `prescale` clock cycles so the same `prescale` setting pairs TX and RX. It sits between the host-side register/FIFO logic and the `tx_out` pad.

## Interface
- `DATA_WIDTH`, 8, payload bits per frame (1–16)
- `CNT_WIDTH`, 6, width of the internal per-bit cycle counter; must hold 32
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `prescale`  in  5  clock cycles per serial bit; 8 and 16 are the supported operating values; sampled at frame acceptance
- `p_data`  in  DATA_WIDTH  word to send; sampled at frame acceptance
- `data_valid`  in  1  request to send `p_data`
- `par_en`  in  1  add parity bit (present only with `UART_TX_PARITY_EN`)
- `par_typ`  in  1  0 = even, 1 = odd (present only with `UART_TX_PARITY_EN`)
- `tx_out`  out  1  serial line, idle high, registered
- `busy`  out  1  frame in progress; `data_valid` ignored while high
- `tx_done`  out  1  one-cycle pulse when the stop bit completes

## Operation
- FSM states are IDLE, START, DATA, PARITY, STOP.
- Reset values:
  - state is IDLE.
  - `tx_out`=1, `busy`=0, `tx_done`=0.
  - Bit counter, cycle counter and shift register are 0.
- IDLE → START: on a rising edge with `data_valid`=1.
  - The same edge latches `p_data` into the shift register, latches `prescale`, latches `par_en`/`par_typ`, and computes parity.
  - The same edge sets `busy`=1 and `tx_out`=0.
- Each bit state holds `tx_out` constant for exactly P cycles, where P is the latched prescale. A latched value of 0 is treated as 1.
- The cycle counter runs 0..P-1 and wraps to 0 on each bit boundary.
- START → DATA after P cycles. `tx_out` is then the shift register LSB.
- DATA:
  - Shifts right at each bit boundary.
  - The bit counter runs 0..DATA_WIDTH-1.
  - After DATA_WIDTH bits, goes to PARITY if parity is enabled, else STOP.
- PARITY bit value:
  - Even parity: XOR of the latched data.
  - Odd parity: the inverse of that XOR.
  - Goes to STOP after P cycles.
- STOP drives `tx_out`=1 for P cycles. On the last edge of STOP:
  - state → IDLE
  - `busy` → 0
  - `tx_done` → 1 for one cycle
- `data_valid` is not accepted on the edge that leaves STOP. Minimum inter-frame gap is one idle cycle.
- Changes to `p_data` or `prescale` during `busy` have no effect on the current frame.
- A reset assertion at any point forces the reset values immediately (asynchronously) and aborts the frame. No partial stop bit is generated.

## Timing
- Acceptance edge is E0. `tx_out` falls at E0, so it is visible in the cycle after E0.
- Start bit occupies E0..E0+P.
- Data bit k drives from E0+(1+k)·P.
- Frame length F = (2 + DATA_WIDTH + par) · P cycles, where par=1 if parity is enabled.
- `busy` is high from E0 to E0+F. `tx_done` is high for the cycle after E0+F.
- Earliest next acceptance edge is E0+F+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - `par_en` and `par_typ` ports exist.
  - The PARITY state is built.
  - The frame includes a parity bit when `par_en`=1.
- Not defined:
  - Those ports and the PARITY state are removed.
  - Frames are always start + data + stop.

## Test plan
- Reset: with `rst` held high, `tx_out`=1, `busy`=0, `tx_done`=0. After release with `data_valid`=0 for 100 cycles, `tx_out` stays 1.
- Basic frame, no parity:
  - Stimulus: DATA_WIDTH=8, prescale=16, `p_data`=0xA5.
  - Line: 0, then 1,0,1,0,0,1,0,1, then 1, each held 16 cycles.
  - `busy` high for 160 cycles, then a single `tx_done` pulse.
- Parity (macro on), `p_data`=0xA5, prescale=8:
  - Even parity gives parity bit 0; odd parity gives 1.
  - Frame is 88 cycles.
  - `p_data`=0x07 with even parity gives parity bit 1.
- Handshake:
  - `data_valid` held high continuously with 0x3C then 0xC3 gives two complete frames separated by exactly one idle-high cycle.
  - Changing `p_data` or `prescale` mid-frame does not alter the line.
- Mid-frame reset: `rst` pulsed during data bit 3 makes `tx_out`=1 and `busy`=0 immediately. The next request (0x55) transmits a correct full frame.
- prescale=0 gives 1 cycle per bit: a 10-cycle frame for DATA_WIDTH=8 with no parity.

Source files
------------

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - framed UART transmitter: start, LSB-first data, optional parity, stop
// Define UART_TX_PARITY_EN to build the par_en/par_typ ports and the PARITY state.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            prescale,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
`ifdef UART_TX_PARITY_EN
  input  logic                  par_en,
  input  logic                  par_typ,
`endif
  output logic                  tx_out,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BIT_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state, state_next;
  logic                  tx_next, busy_next, done_next;
  logic [CNT_WIDTH-1:0]  cyc_cnt, cyc_next;
  logic [CNT_WIDTH-1:0]  presc_lat, presc_next;
  logic [BIT_W-1:0]      bit_cnt, bit_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  last_cyc;
`ifdef UART_TX_PARITY_EN
  logic                  par_en_lat, par_en_next;
  logic                  par_bit, par_bit_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
      cyc_cnt   <= '0;
      presc_lat <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
      par_en_lat <= 1'b0;
      par_bit    <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      tx_out    <= tx_next;
      busy      <= busy_next;
      tx_done   <= done_next;
      cyc_cnt   <= cyc_next;
      presc_lat <= presc_next;
      bit_cnt   <= bit_next;
      shift_reg <= shift_next;
`ifdef UART_TX_PARITY_EN
      par_en_lat <= par_en_next;
      par_bit    <= par_bit_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    tx_next    = tx_out;
    busy_next  = busy;
    done_next  = 1'b0;
    cyc_next   = cyc_cnt;
    presc_next = presc_lat;
    bit_next   = bit_cnt;
    shift_next = shift_reg;
`ifdef UART_TX_PARITY_EN
    par_en_next  = par_en_lat;
    par_bit_next = par_bit;
`endif
    // Bit boundary: the counter has spent P cycles in the current bit.
    last_cyc = (cyc_cnt == presc_lat - CNT_WIDTH'(1));

    if (state != IDLE) begin
      cyc_next = last_cyc ? '0 : cyc_cnt + CNT_WIDTH'(1);
    end

    case (state)
      IDLE: begin
        if (data_valid) begin
          state_next = START;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
          cyc_next   = '0;
          bit_next   = '0;
          shift_next = p_data;
          presc_next = (prescale == 5'd0) ? CNT_WIDTH'(1) : CNT_WIDTH'(prescale);
`ifdef UART_TX_PARITY_EN
          par_en_next  = par_en;
          par_bit_next = (^p_data) ^ par_typ;
`endif
        end
      end
      START: begin
        if (last_cyc) begin
          state_next = DATA;
          tx_next    = shift_reg[0];
          shift_next = shift_reg >> 1;
          bit_next   = '0;
        end
      end
      DATA: begin
        if (last_cyc) begin
          if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_lat) begin
              state_next = PARITY;
              tx_next    = par_bit;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
`else
            state_next = STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            bit_next   = bit_cnt + BIT_W'(1);
            tx_next    = shift_reg[0];
            shift_next = shift_reg >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (last_cyc) begin
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (last_cyc) begin
          state_next = IDLE;
          tx_next    = 1'b1;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - directed self-checking bench for uart_tx_frame
// Parity steps are compiled in when UART_TX_PARITY_EN is defined.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] prescale = 5'd16;
  logic [7:0] p_data = 8'h00;
  logic       data_valid = 1'b0;
`ifdef UART_TX_PARITY_EN
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
`endif
  logic       tx_out, busy, tx_done;

  int checks = 0;
  int errors = 0;

  uart_tx_frame #(.DATA_WIDTH(8), .CNT_WIDTH(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .prescale   (prescale),
    .p_data     (p_data),
    .data_valid (data_valid),
`ifdef UART_TX_PARITY_EN
    .par_en     (par_en),
    .par_typ    (par_typ),
`endif
    .tx_out     (tx_out),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  // Observed vector is {tx_out, busy, tx_done}.
  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic start_frame(input logic [7:0] d, input logic [4:0] p, input bit hold);
    p_data     = d;
    prescale   = p;
    data_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) data_valid = 1'b0;
  endtask

  // Sample j shows what was driven at edge E0+j; ends on sample F.
  task automatic check_frame(input string tag, input logic [17:0] frame, input int nbits, input int p);
    int f;
    f = nbits * p;
    for (int j = 0; j <= f; j++) begin
      if (j < f) check(tag, {frame[j / p], 1'b1, 1'b0}, {tx_out, busy, tx_done});
      else       check({tag, "_done"}, {tx_out, busy, tx_done}, 3'b101);
      if (j < f) @(negedge clk);
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check(tag, {tx_out, busy, tx_done}, 3'b100);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_held", {tx_out, busy, tx_done}, 3'b100);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_after_reset", {tx_out, busy, tx_done}, 3'b100);
    end

    // 0xA5 at 16 cycles per bit: 0,1,0,1,0,0,1,0,1,1
    start_frame(8'hA5, 5'd16, 1'b0);
    check_frame("a5_p16", {1'b1, 8'hA5, 1'b0}, 10, 16);
    check_idle("a5_p16_pulse_end");

    // Back-to-back with data_valid held; p_data changes mid-frame.
    @(negedge clk);
    start_frame(8'h3C, 5'd8, 1'b1);
    p_data = 8'hC3;
    check_frame("b2b_3c", {1'b1, 8'h3C, 1'b0}, 10, 8);
    start_frame(8'hC3, 5'd8, 1'b0);
    check_frame("b2b_c3", {1'b1, 8'hC3, 1'b0}, 10, 8);
    check_idle("b2b_end");

    // p_data and prescale altered right after acceptance.
    @(negedge clk);
    start_frame(8'h5A, 5'd8, 1'b0);
    p_data   = 8'hFF;
    prescale = 5'd3;
    check_frame("midchg_5a", {1'b1, 8'h5A, 1'b0}, 10, 8);
    check_idle("midchg_end");

    // prescale 0 behaves as 1 cycle per bit.
    @(negedge clk);
    start_frame(8'h96, 5'd0, 1'b0);
    check_frame("p0_96", {1'b1, 8'h96, 1'b0}, 10, 1);
    check_idle("p0_end");

    // Reset during data bit 3 (samples 64..79 at P=16).
    @(negedge clk);
    start_frame(8'hA5, 5'd16, 1'b0);
    repeat (70) @(negedge clk);
    check("pre_rst_bit3", {tx_out, busy, tx_done}, 3'b010);
    #2 rst = 1'b1;
    #1 check("rst_async", {tx_out, busy, tx_done}, 3'b100);
    @(negedge clk);
    rst = 1'b0;
    check_idle("rst_released");
    start_frame(8'h55, 5'd16, 1'b0);
    check_frame("post_rst_55", {1'b1, 8'h55, 1'b0}, 10, 16);
    check_idle("post_rst_end");

`ifdef UART_TX_PARITY_EN
    @(negedge clk);
    par_en = 1'b1; par_typ = 1'b0;
    start_frame(8'hA5, 5'd8, 1'b0);
    check_frame("par_even_a5", {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 8);
    check_idle("par_even_a5_end");
    @(negedge clk);
    par_typ = 1'b1;
    start_frame(8'hA5, 5'd8, 1'b0);
    check_frame("par_odd_a5", {1'b1, 1'b1, 8'hA5, 1'b0}, 11, 8);
    check_idle("par_odd_a5_end");
    @(negedge clk);
    par_typ = 1'b0;
    start_frame(8'h07, 5'd8, 1'b0);
    check_frame("par_even_07", {1'b1, 1'b1, 8'h07, 1'b0}, 11, 8);
    check_idle("par_even_07_end");
    par_en = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
